dm_arbiter: RTL and testbench
=============================

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, shall set the data-memory address width.
REQ-002 Parameter WDATA_W, default 16, shall set the write-data width.
REQ-003 Parameter RDATA_W, default 8, shall set the read-data width.
REQ-004 Parameter MAX_HOLD, default 4, shall set the maximum consecutive grants to one owner while the other port is requesting.
REQ-005 Port clk, input, 1: the single clock; all state changes on rising edge.
REQ-006 Port rst, input, 1: reset, synchronous and active-high.
REQ-007 Ports c_req, c_we, input, 1 each: core access request and write enable.
REQ-008 Ports c_addr (ADDR_W) and c_wdata (WDATA_W), inputs: core address and write data.
REQ-009 Ports c_gnt, c_rvalid, outputs, 1 each: core grant and core read-data valid.
REQ-010 Port c_rdata, output, RDATA_W: core read data.
REQ-011 Ports h_req, h_we, h_addr, h_wdata, h_gnt, h_rvalid, h_rdata shall mirror the c_* ports with identical directions and widths, for the host/loader port.
REQ-012 Ports mem_we (1), mem_addr (ADDR_W) and mem_wdata (WDATA_W), outputs: data-memory write enable, shared read/write address, and write data.
REQ-013 Port mem_rdata, input, RDATA_W: data-memory read data, valid one cycle after the address is presented.

Function
REQ-014 FSM states shall be IDLE, OWN_C and OWN_H, with a hold counter of width clog2(MAX_HOLD+1).
REQ-015 Grant shall be combinational from the current state and the req inputs, with at most one gnt high per cycle.
REQ-016 In IDLE with both requests high, the core shall win; a lone request shall win.
REQ-017 In OWN_x, x shall keep the grant while x_req is high, unless the other port is requesting and the hold counter equals MAX_HOLD.
REQ-018 In OWN_x with x_req low and the other port requesting, the other port shall be granted in the same cycle.
REQ-019 With no request, no grant shall issue and the next state shall be IDLE.
REQ-020 The next state shall be OWN_<granted port> whenever a grant issues.
REQ-021 The hold counter shall be 1 on the first grant to a new owner and increment per consecutive grant to the same owner, saturating at MAX_HOLD.
REQ-022 The hold counter shall reset to 1 on an ownership switch and to 0 when no grant issues.
REQ-023 mem_addr, mem_wdata and mem_we shall be the granted port's addr, wdata and we; with no grant, mem_we shall be 0 and addr/wdata shall hold the core port values.
REQ-024 x_rvalid shall be registered: high exactly one cycle after a granted read (x_gnt=1, x_we=0) by x, else low.
REQ-025 c_rdata and h_rdata shall both pass through mem_rdata combinationally; data is meaningful only when the matching rvalid is high.
REQ-026 A granted write shall complete in its grant cycle and produce no rvalid.
REQ-027 An ungranted request shall not be queued; the requester shall hold req, addr, we and wdata until it sees gnt.
REQ-028 Back-to-back reads by alternating owners shall each get their own rvalid on consecutive cycles with no bubble.

Reset
REQ-029 On rst=1 at a clock edge, the state shall be IDLE, the hold counter 0, and c_rvalid and h_rvalid 0.
REQ-030 While rst=1, c_gnt, h_gnt and mem_we shall be forced to 0.
REQ-031 A read granted in the cycle rst is asserted shall produce no rvalid after reset.

Structure
REQ-032 State encodings and the default ADDR_W/WDATA_W/RDATA_W constants shall live in the shared package dm_pkg.
REQ-033 A single sub-module, rr_hold_fsm, shall hold the state, hold counter and grant logic; the datapath mux and rvalid registers shall stay in dm_arbiter.

Verification
REQ-034 Scenario, core-only write/read: core writes addr 0x10, data 0x00A5, then reads 0x10 -> c_gnt on both cycles, one cycle later c_rvalid=1 with c_rdata=0xA5, and h_gnt stays 0.
REQ-035 Scenario, simultaneous start: c_req and h_req rise together from IDLE -> core granted first.
REQ-036 Scenario, hold limit with MAX_HOLD=4: both ports request continuously -> grant pattern C,C,C,C,H,H,H,H,C...
REQ-037 Scenario, early release: the owner drops req after 2 grants while the other port is requesting -> the other port is granted in the same cycle, and its hold counter reads 1.
REQ-038 Scenario, reset mid-read: host read granted at 0x20 in the cycle rst=1 -> h_rvalid stays 0, and state is IDLE the next cycle.
REQ-039 Scenario, alternating reads: core reads 0x01, then host reads 0x02 on the next cycle -> c_rvalid, then h_rvalid on consecutive cycles, with the matching data.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_C = 2'd1,
    OWN_H = 2'd2
  } arb_state_t;

  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_WDATA_W  = 16;
  localparam int DEF_RDATA_W  = 8;
  localparam int DEF_MAX_HOLD = 4;

endpackage

// File: rtl/dm_arbiter_rr_hold_fsm.sv
// Ownership FSM with hold counter: decides which port owns the memory each cycle.
module rr_hold_fsm
  import dm_pkg::*;
#(
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic clk,
  input  logic rst,
  input  logic c_req,
  input  logic h_req,
  output logic c_gnt,
  output logic h_gnt
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  arb_state_t          state_r;
  arb_state_t          state_next_s;
  logic [HOLD_W-1:0]   hold_r;
  logic [HOLD_W-1:0]   hold_next_s;
  logic                at_max_s;
  logic                gnt_c_s;
  logic                gnt_h_s;

  assign at_max_s = (hold_r == HOLD_W'(MAX_HOLD));
  assign c_gnt    = gnt_c_s;
  assign h_gnt    = gnt_h_s;

  // Grant decision and next-state/hold computation
  always_comb begin
    gnt_c_s      = 1'b0;
    gnt_h_s      = 1'b0;
    state_next_s = IDLE;
    hold_next_s  = {HOLD_W{1'b0}};

    case (state_r)
      IDLE: begin
        if (c_req) begin
          gnt_c_s = 1'b1;
        end else if (h_req) begin
          gnt_h_s = 1'b1;
        end else begin
          gnt_c_s = 1'b0;
        end
      end
      OWN_C: begin
        if (c_req && !(h_req && at_max_s)) begin
          gnt_c_s = 1'b1;
        end else if (h_req) begin
          gnt_h_s = 1'b1;
        end else begin
          gnt_c_s = 1'b0;
        end
      end
      OWN_H: begin
        if (h_req && !(c_req && at_max_s)) begin
          gnt_h_s = 1'b1;
        end else if (c_req) begin
          gnt_c_s = 1'b1;
        end else begin
          gnt_h_s = 1'b0;
        end
      end
      default: begin
        gnt_c_s = 1'b0;
        gnt_h_s = 1'b0;
      end
    endcase

    // Reset suppresses every grant so nothing reaches memory during reset
    if (rst) begin
      gnt_c_s = 1'b0;
      gnt_h_s = 1'b0;
    end else begin
      gnt_c_s = gnt_c_s;
    end

    if (gnt_c_s) begin
      state_next_s = OWN_C;
      hold_next_s  = (state_r != OWN_C) ? HOLD_W'(1) :
                     (at_max_s ? hold_r : hold_r + HOLD_W'(1));
    end else if (gnt_h_s) begin
      state_next_s = OWN_H;
      hold_next_s  = (state_r != OWN_H) ? HOLD_W'(1) :
                     (at_max_s ? hold_r : hold_r + HOLD_W'(1));
    end else begin
      state_next_s = IDLE;
      hold_next_s  = {HOLD_W{1'b0}};
    end
  end

  // State and hold counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      hold_r  <= {HOLD_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      hold_r  <= hold_next_s;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port (core/host) arbiter in front of a single-port data memory.
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int WDATA_W  = DEF_WDATA_W,
  parameter int RDATA_W  = DEF_RDATA_W,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               c_req,
  input  logic               c_we,
  input  logic [ADDR_W-1:0]  c_addr,
  input  logic [WDATA_W-1:0] c_wdata,
  output logic               c_gnt,
  output logic               c_rvalid,
  output logic [RDATA_W-1:0] c_rdata,
  input  logic               h_req,
  input  logic               h_we,
  input  logic [ADDR_W-1:0]  h_addr,
  input  logic [WDATA_W-1:0] h_wdata,
  output logic               h_gnt,
  output logic               h_rvalid,
  output logic [RDATA_W-1:0] h_rdata,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [WDATA_W-1:0] mem_wdata,
  input  logic [RDATA_W-1:0] mem_rdata
);

  logic c_gnt_s;
  logic h_gnt_s;
  logic c_rvalid_r;
  logic h_rvalid_r;

  rr_hold_fsm #(
    .MAX_HOLD (MAX_HOLD)
  ) u_fsm (
    .clk   (clk),
    .rst   (rst),
    .c_req (c_req),
    .h_req (h_req),
    .c_gnt (c_gnt_s),
    .h_gnt (h_gnt_s)
  );

  assign c_gnt = c_gnt_s;
  assign h_gnt = h_gnt_s;

  // Memory port follows the host only when it holds the grant; core otherwise
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = c_addr;
    mem_wdata = c_wdata;
    if (h_gnt_s) begin
      mem_we    = h_we;
      mem_addr  = h_addr;
      mem_wdata = h_wdata;
    end else if (c_gnt_s) begin
      mem_we    = c_we;
    end else begin
      mem_we    = 1'b0;
    end
  end

  // Read-data valid tracks a granted read one cycle later (memory latency)
  always_ff @(posedge clk) begin
    if (rst) begin
      c_rvalid_r <= 1'b0;
      h_rvalid_r <= 1'b0;
    end else begin
      c_rvalid_r <= c_gnt_s & ~c_we;
      h_rvalid_r <= h_gnt_s & ~h_we;
    end
  end

  assign c_rvalid = c_rvalid_r;
  assign h_rvalid = h_rvalid_r;
  assign c_rdata  = mem_rdata;
  assign h_rdata  = mem_rdata;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios plus randomized traffic vs a reference model.
module tb_dm_arbiter;
  import dm_pkg::*;

  localparam int MAXH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        c_req = 1'b0, c_we = 1'b0, h_req = 1'b0, h_we = 1'b0;
  logic [7:0]  c_addr = 8'd0, h_addr = 8'd0;
  logic [15:0] c_wdata = 16'd0, h_wdata = 16'd0;
  logic        c_gnt, c_rvalid, h_gnt, h_rvalid, mem_we;
  logic [7:0]  c_rdata, h_rdata, mem_addr;
  logic [15:0] mem_wdata;
  logic [7:0]  mem_rdata = 8'd0;

  int n_total = 0;
  int n_bad   = 0;

  dm_arbiter #(.ADDR_W(8), .WDATA_W(16), .RDATA_W(8), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] seed_word(input logic [7:0] a);
    return {a ^ 8'h5A, a + 8'h33};
  endfunction

  // Memory device: one-cycle registered read, write on grant edge
  logic [15:0] dev_mem [256];
  logic        dev_wr  [256];
  always @(posedge clk) begin
    if (mem_we) begin
      dev_mem[mem_addr] <= mem_wdata;
      dev_wr[mem_addr]  <= 1'b1;
    end
    mem_rdata <= (dev_wr[mem_addr] === 1'b1) ? dev_mem[mem_addr][7:0] : seed_word(mem_addr)[7:0];
  end

  // Reference model state: owner 0=none 1=core 2=host, streak length, reference memory
  int          m_owner = 0;
  int          m_cnt   = 0;
  logic [15:0] ref_mem [256];
  logic        ref_wr  [256];

  logic [1:0]  exp_g, obs_g;
  logic        exp_we, obs_we;
  logic [7:0]  exp_addr, obs_addr;
  logic [15:0] exp_wd, obs_wd;
  logic        exp_crv, exp_hrv, obs_crv, obs_hrv;
  logic [7:0]  exp_rd, obs_crd, obs_hrd;
  int          obs_hold;
  arb_state_t  obs_state;

  function automatic logic [1:0] model_grant(input logic cr, input logic hr);
    logic [1:0] req;
    int other;
    req = {hr, cr};
    if (m_owner == 0) return cr ? 2'd1 : (hr ? 2'd2 : 2'd0);
    other = 3 - m_owner;
    if (req[m_owner-1] && !(req[other-1] && m_cnt == MAXH)) return 2'(m_owner);
    if (req[other-1]) return 2'(other);
    return 2'd0;
  endfunction

  task automatic run_cycle(input logic r, input logic cr, input logic cw, input logic [7:0] ca,
                           input logic [15:0] cd, input logic hr, input logic hw,
                           input logic [7:0] ha, input logic [15:0] hd);
    logic [1:0] g;
    logic [7:0] ra;
    rst = r; c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
    h_req = hr; h_we = hw; h_addr = ha; h_wdata = hd;
    g        = r ? 2'd0 : model_grant(cr, hr);
    exp_g    = g;
    exp_we   = (g == 2'd1) ? cw : ((g == 2'd2) ? hw : 1'b0);
    exp_addr = (g == 2'd2) ? ha : ca;
    exp_wd   = (g == 2'd2) ? hd : cd;
    @(negedge clk);
    obs_g = {h_gnt, c_gnt}; obs_we = mem_we; obs_addr = mem_addr; obs_wd = mem_wdata;
    exp_crv = (g == 2'd1) && !cw;
    exp_hrv = (g == 2'd2) && !hw;
    ra      = (g == 2'd2) ? ha : ca;
    exp_rd  = (ref_wr[ra] === 1'b1) ? ref_mem[ra][7:0] : seed_word(ra)[7:0];
    if (exp_we) begin
      ref_mem[ra] = exp_wd;
      ref_wr[ra]  = 1'b1;
    end
    if (g == 2'd0) begin
      m_owner = 0; m_cnt = 0;
    end else if (int'(g) == m_owner) begin
      m_cnt = (m_cnt < MAXH) ? m_cnt + 1 : MAXH;
    end else begin
      m_owner = int'(g); m_cnt = 1;
    end
    @(posedge clk);
    #1;
    obs_crv = c_rvalid; obs_hrv = h_rvalid; obs_crd = c_rdata; obs_hrd = h_rdata;
    obs_hold  = int'(dut.u_fsm.hold_r);
    obs_state = dut.u_fsm.state_r;
  endtask

  task automatic idle_cycle();
    run_cycle(1'b0, 1'b0, 1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 8'd0, 16'd0);
  endtask

  task automatic test_reset();
    run_cycle(1'b1, 1'b1, 1'b1, 8'h05, 16'h1234, 1'b1, 1'b0, 8'h06, 16'h0);
    n_total++; if ({obs_g, obs_we} !== 3'b000) begin n_bad++; $display("FAIL reset_gnt: got %b want 000", {obs_g, obs_we}); end
    n_total++; if ({obs_crv, obs_hrv} !== 2'b00) begin n_bad++; $display("FAIL reset_rvalid: got %b want 00", {obs_crv, obs_hrv}); end
    n_total++; if (obs_state !== IDLE || obs_hold != 0) begin n_bad++; $display("FAIL reset_state: got %0d/%0d want IDLE/0", obs_state, obs_hold); end
  endtask

  task automatic test_core_write_read();
    idle_cycle();
    run_cycle(1'b0, 1'b1, 1'b1, 8'h10, 16'h00A5, 1'b0, 1'b0, 8'h00, 16'h0);
    n_total++; if (obs_g !== 2'b01 || obs_we !== 1'b1 || obs_addr !== 8'h10) begin n_bad++; $display("FAIL core_write: got g=%b we=%b a=%h", obs_g, obs_we, obs_addr); end
    n_total++; if (obs_crv !== 1'b0) begin n_bad++; $display("FAIL write_no_rvalid: got %b want 0", obs_crv); end
    run_cycle(1'b0, 1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0);
    n_total++; if (obs_g !== 2'b01) begin n_bad++; $display("FAIL core_read_gnt: got %b want 01", obs_g); end
    n_total++; if (obs_crv !== 1'b1 || obs_hrv !== 1'b0 || obs_crd !== 8'hA5) begin n_bad++; $display("FAIL core_read_data: got rv=%b hrv=%b d=%h want 1 0 a5", obs_crv, obs_hrv, obs_crd); end
  endtask

  task automatic test_simultaneous();
    idle_cycle();
    run_cycle(1'b0, 1'b1, 1'b0, 8'h03, 16'h0, 1'b1, 1'b0, 8'h04, 16'h0);
    n_total++; if (obs_g !== 2'b01) begin n_bad++; $display("FAIL simultaneous: got %b want 01", obs_g); end
  endtask

  task automatic test_hold_limit();
    logic [1:0] pat;
    idle_cycle();
    for (int i = 0; i < 12; i++) begin
      run_cycle(1'b0, 1'b1, 1'b0, 8'h07, 16'h0, 1'b1, 1'b0, 8'h08, 16'h0);
      pat = (((i / MAXH) % 2) == 0) ? 2'b01 : 2'b10;
      n_total++; if (obs_g !== pat) begin n_bad++; $display("FAIL hold_limit[%0d]: got %b want %b", i, obs_g, pat); end
    end
  endtask

  task automatic test_early_release();
    idle_cycle();
    for (int i = 0; i < 2; i++) begin
      run_cycle(1'b0, 1'b1, 1'b0, 8'h09, 16'h0, 1'b1, 1'b0, 8'h0A, 16'h0);
      n_total++; if (obs_g !== 2'b01 || obs_hold != i + 1) begin n_bad++; $display("FAIL early_own[%0d]: got g=%b h=%0d", i, obs_g, obs_hold); end
    end
    run_cycle(1'b0, 1'b0, 1'b0, 8'h09, 16'h0, 1'b1, 1'b0, 8'h0A, 16'h0);
    n_total++; if (obs_g !== 2'b10) begin n_bad++; $display("FAIL early_switch: got %b want 10", obs_g); end
    n_total++; if (obs_hold != 1 || obs_state !== OWN_H) begin n_bad++; $display("FAIL early_hold: got %0d/%0d want 1/OWN_H", obs_hold, obs_state); end
  endtask

  task automatic test_reset_mid_read();
    run_cycle(1'b0, 1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 1'b0, 8'h20, 16'h0);
    run_cycle(1'b1, 1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 1'b0, 8'h20, 16'h0);
    n_total++; if (obs_g !== 2'b00 || obs_we !== 1'b0) begin n_bad++; $display("FAIL rst_read_gnt: got %b/%b want 00/0", obs_g, obs_we); end
    n_total++; if (obs_hrv !== 1'b0 || obs_state !== IDLE) begin n_bad++; $display("FAIL rst_read_state: got rv=%b st=%0d want 0 IDLE", obs_hrv, obs_state); end
    idle_cycle();
    n_total++; if (obs_hrv !== 1'b0) begin n_bad++; $display("FAIL rst_read_late: got %b want 0", obs_hrv); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e1, e2;
    idle_cycle();
    run_cycle(1'b0, 1'b1, 1'b0, 8'h01, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0);
    e1 = exp_rd;
    n_total++; if (obs_crv !== 1'b1 || obs_hrv !== 1'b0 || obs_crd !== e1) begin n_bad++; $display("FAIL b2b_core: got %b%b d=%h want 10 %h", obs_crv, obs_hrv, obs_crd, e1); end
    run_cycle(1'b0, 1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 1'b0, 8'h02, 16'h0);
    e2 = exp_rd;
    n_total++; if (obs_crv !== 1'b0 || obs_hrv !== 1'b1 || obs_hrd !== e2) begin n_bad++; $display("FAIL b2b_host: got %b%b d=%h want 01 %h", obs_crv, obs_hrv, obs_hrd, e2); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      run_cycle(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom), 8'($urandom_range(0, 15)),
                16'($urandom), 1'($urandom), 1'($urandom), 8'($urandom_range(0, 15)), 16'($urandom));
      n_total++;
      if ({obs_g, obs_we, obs_addr, obs_wd} !== {exp_g, exp_we, exp_addr, exp_wd}) begin
        n_bad++; $display("FAIL rand_mem[%0d]: got %b %b %h %h want %b %b %h %h", i, obs_g, obs_we, obs_addr, obs_wd, exp_g, exp_we, exp_addr, exp_wd);
      end
      n_total++;
      if ({obs_crv, obs_hrv} !== {exp_crv, exp_hrv}) begin n_bad++; $display("FAIL rand_rvalid[%0d]: got %b%b want %b%b", i, obs_crv, obs_hrv, exp_crv, exp_hrv); end
      if (exp_crv || exp_hrv) begin
        n_total++;
        if ((exp_crv ? obs_crd : obs_hrd) !== exp_rd) begin n_bad++; $display("FAIL rand_rdata[%0d]: got %h want %h", i, exp_crv ? obs_crd : obs_hrd, exp_rd); end
      end
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_core_write_read();
    test_simultaneous();
    test_hold_limit();
    test_early_release();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
